// File: rtl/ndma_pkg.sv
// ndma_pkg: shared types and constants for the NanoDMA transfer sequencer.
//   xfer_state_t     : sequencer state encoding (6 states, 3 bits)
//   ADDR_INC_DEFAULT : default byte stride per 32-bit word
package ndma_pkg;

  localparam int unsigned ADDR_INC_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_FINISH  = 3'd5
  } xfer_state_t;

endpackage

// File: rtl/ndma_xfer_ctrl.sv
// ndma_xfer_ctrl: single-channel NanoDMA transfer sequencer.
// Walks a descriptor word by word: read request -> capture word in a
// one-word buffer -> write request -> advance addresses / count.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, abort_i, src_addr_i, dst_addr_i, len_i, src_inc_i, dst_inc_i : descriptor / control
//   rd_req_o, rd_addr_o, rd_valid_i, rd_data_i                            : read manager
//   wr_req_o, wr_addr_o, wr_data_o, wr_done_i                             : write manager
//   busy_o, done_o, aborted_o, irq_o, irq_clr_i                           : status / interrupt
module ndma_xfer_ctrl
  import ndma_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int ADDR_INC = ADDR_INC_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             src_inc_i,
  input  logic             dst_inc_i,
  output logic             rd_req_o,
  output logic [31:0]      rd_addr_o,
  input  logic             rd_valid_i,
  input  logic [31:0]      rd_data_i,
  output logic             wr_req_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  input  logic             wr_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             irq_o,
  input  logic             irq_clr_i
);

  localparam logic [31:0] INC32 = 32'(ADDR_INC);

  xfer_state_t      state_q, state_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [31:0]      buf_q, buf_d;
  logic             abort_pend_q, abort_pend_d;
  logic             aborted_q, aborted_d;
  logic             irq_q, irq_d;

  logic last_word;
  logic abort_now;

  assign last_word = (remaining_q == LEN_W'(1));
  // An abort arriving in the same cycle as wr_done_i still ends the transfer
  // after the word that just completed.
  assign abort_now = abort_pend_q | abort_i;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      remaining_q  <= '0;
      buf_q        <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      remaining_q  <= remaining_d;
      buf_q        <= buf_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      irq_q        <= irq_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = (len_i == '0) ? S_FINISH : S_RD_REQ;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: if (rd_valid_i) state_d = S_WR_REQ;
      S_WR_REQ:  state_d = S_WR_WAIT;
      S_WR_WAIT: if (wr_done_i) state_d = (last_word || abort_now) ? S_FINISH : S_RD_REQ;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath / status register updates
  always_comb begin
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    remaining_d  = remaining_q;
    buf_d        = buf_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    irq_d        = irq_q;

    if (state_q == S_IDLE && start_i) begin
      cur_src_d   = src_addr_i;
      cur_dst_d   = dst_addr_i;
      remaining_d = len_i;
      aborted_d   = 1'b0;
    end

    if (state_q == S_RD_WAIT && rd_valid_i) buf_d = rd_data_i;

    if (state_q == S_WR_WAIT && wr_done_i) begin
      // Guard keeps the counter from wrapping even if wr_done_i misbehaves.
      if (remaining_q != '0) remaining_d = remaining_q - LEN_W'(1);
      if (src_inc_i) cur_src_d = cur_src_q + INC32;
      if (dst_inc_i) cur_dst_d = cur_dst_q + INC32;
    end

    if (state_q != S_IDLE && abort_i) abort_pend_d = 1'b1;

    // FINISH wins over a clear on both abort_pend and irq.
    if (state_q == S_FINISH) begin
      abort_pend_d = 1'b0;
      aborted_d    = abort_pend_q;
      irq_d        = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    rd_req_o = (state_q == S_RD_REQ);
    wr_req_o = (state_q == S_WR_REQ);
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_FINISH);
  end

  // Buffer drives wr_data_o directly so it stays stable through WR_WAIT.
  assign rd_addr_o = cur_src_q;
  assign wr_addr_o = cur_dst_q;
  assign wr_data_o = buf_q;
  assign aborted_o = aborted_q;
  assign irq_o     = irq_q;

endmodule

// File: doc/ndma_xfer_ctrl.md
Name: ndma_xfer_ctrl

Overview:
Single-channel transfer sequencer for NanoDMA. It takes a programmed descriptor (source, destination, word count, increment modes) and walks it word by word. For each word it issues a request to the OBI read manager, captures the returned word in a one-word holding buffer, then hands it to the write manager. It sits between the register/config front end and the read/write manager pair, and reports busy, done and interrupt status.

Parameters:
LEN_W, 16, width of the word-count field and remaining-count counter
ADDR_INC, 4, byte increment applied per word when increment is enabled

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  launch transfer; sampled only in IDLE
abort_i  in  1  request abort; sampled any cycle while busy
src_addr_i  in  32  source byte address, latched on accepted start
dst_addr_i  in  32  destination byte address, latched on accepted start
len_i  in  LEN_W  number of 32-bit words, latched on accepted start
src_inc_i  in  1  1: advance source by ADDR_INC per word; 0: fixed address
dst_inc_i  in  1  1: advance destination by ADDR_INC per word; 0: fixed address
rd_req_o  out  1  one-cycle read request pulse to the read manager
rd_addr_o  out  32  read address; valid while rd_req_o=1
rd_valid_i  in  1  read data valid from the read manager, one cycle
rd_data_i  in  32  read data, qualified by rd_valid_i
wr_req_o  out  1  one-cycle write request pulse to the write manager
wr_addr_o  out  32  write address; valid while wr_req_o=1
wr_data_o  out  32  write data; held stable from wr_req_o until wr_done_i
wr_done_i  in  1  write completed, one cycle
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse on completion or abort
aborted_o  out  1  sticky: last transfer ended by abort; cleared on next accepted start
irq_o  out  1  level interrupt; set with done_o
irq_clr_i  in  1  clears irq_o; a set in the same cycle wins

Behaviour:
- Reset, async on rst_i=1: state IDLE. All outputs 0. Address registers, count and data buffer 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE
  - start_i=1 latches the descriptor: cur_src=src_addr_i, cur_dst=dst_addr_i, remaining=len_i. aborted_o is cleared.
  - len_i=0: go to FINISH, no bus activity.
  - Otherwise go to RD_REQ.
- RD_REQ
  - Assert rd_req_o=1 and rd_addr_o=cur_src for exactly one cycle, then go to RD_WAIT.
  - rd_req_o is never high for two consecutive cycles.
- RD_WAIT
  - On rd_valid_i: capture rd_data_i into the buffer and go to WR_REQ.
  - rd_valid_i outside RD_WAIT is ignored.
- WR_REQ
  - Assert wr_req_o=1, wr_addr_o=cur_dst, wr_data_o=buffer for one cycle, then go to WR_WAIT.
- WR_WAIT
  - On wr_done_i: decrement remaining; cur_src += ADDR_INC if src_inc_i; cur_dst += ADDR_INC if dst_inc_i.
  - Address arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000.
  - Increment flags are live inputs; the config block holds them stable while busy.
  - Next state: remaining==1 (last word) or abort pending goes to FINISH; otherwise RD_REQ.
- FINISH: done_o=1 for one cycle, irq_o set, aborted_o=abort_pending, abort_pending cleared, go to IDLE.
- busy_o=1 in every state except IDLE.
- Latency per word with zero-wait managers (rd_valid_i and wr_done_i arriving one cycle after the request): 4 cycles. Completion takes N*4+2 cycles from start_i to done_o.
- Abort
  - abort_i while busy sets abort_pending.
  - An outstanding read or write is always allowed to complete; there is no mid-handshake cancel, because the managers cannot retract a request.
  - Abort in RD_WAIT: wait for rd_valid_i, perform the write of that word, then go to FINISH.
  - Abort in IDLE is ignored.
- start_i while busy is ignored.
- rst_i mid-transfer returns to IDLE immediately. Any manager transaction in flight is abandoned; the managers share the same reset.
- Maximum len_i = 2^LEN_W-1. The counter never underflows.

Decomposition:
- ndma_pkg holds xfer_state_t (6-state enum, logic [2:0]) and the ADDR_INC default constant.
- No sub-module. Address/count update is inline; the holding buffer is a single register.

Test Plan:
- Start src=0x1000, dst=0x2000, len=3, both inc, zero-wait managers -> reads at 0x1000, 0x1004, 0x1008; writes at 0x2000, 0x2004, 0x2008 with matching data; done_o at cycle 14; irq_o=1; aborted_o=0.
- len=0 -> no rd_req_o or wr_req_o; done_o 2 cycles after start; busy_o high 1 cycle.
- src_inc=0, dst_inc=1, len=2, src=0x40 -> both reads at 0x40; writes at dst, dst+4.
- src=0xFFFFFFFC, len=2, src_inc=1 -> second read at 0x00000000.
- len=5, abort_i in RD_WAIT of word 2, rd_valid_i delayed 3 cycles -> word 2 read and written, no third rd_req_o, done_o pulse, aborted_o=1. Then a new start with len=1 clears aborted_o.
- irq_clr_i coincident with done_o -> irq_o stays 1. Next-cycle irq_clr_i -> 0. rst_i during WR_WAIT -> all outputs 0, state IDLE.
